// File: rtl/jpeg_output_block_buffer_if.sv
`default_nettype none
// ============================================================================
// jpeg_output_block_buffer_if : write/commit and read/pop bus of the reorder buffer
// Rev 1.0
// ============================================================================
interface jpeg_output_block_buffer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6,
  parameter int BLK_W  = 3
);
  logic [IDX_W-1:0]  wr_idx_i;
  logic [DATA_W-1:0] data_in_i;
  logic              push_i;
  logic              commit_i;
  logic              accept_o;
  logic              flush_i;
  logic              pop_i;
  logic [DATA_W-1:0] data_out_o;
  logic              valid_o;
  logic [31:0]       level_o;
  logic [BLK_W:0]    blocks_o;

  modport master (
    output wr_idx_i, data_in_i, push_i, commit_i, flush_i, pop_i,
    input  accept_o, data_out_o, valid_o, level_o, blocks_o
  );

  modport slave (
    input  wr_idx_i, data_in_i, push_i, commit_i, flush_i, pop_i,
    output accept_o, data_out_o, valid_o, level_o, blocks_o
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_output_block_buffer.sv
`default_nettype none
// ============================================================================
// jpeg_output_block_buffer : block-granular reorder buffer, any-order writes, in-order reads
// Rev 1.0
// ============================================================================
module jpeg_output_block_buffer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6,
  parameter int BLK_W  = 3
) (
  input logic                      clk_i,
  input logic                      rst_i,
  jpeg_output_block_buffer_if.slave bus
);

  localparam int          DEPTH     = 1 << (BLK_W + IDX_W);
  localparam int          PTR_W     = BLK_W + IDX_W + 1;
  localparam logic [31:0] BLK_WORDS = 32'(1) << IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  logic [BLK_W:0]    wr_blk_q, wr_blk_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              valid_q,  valid_d;
  logic [31:0]       level_q,  level_d;

  logic [PTR_W-1:0]  limit;
  logic              read_ok;
  logic              accept;
  logic              wr_en;
  logic              commit_en;
  logic              issue;
  logic              pop_en;

  assign limit   = {wr_blk_q, {IDX_W{1'b0}}};
  assign read_ok = (rd_ptr_q != limit);
  // Equal slot index with differing wrap bits means every slot holds an unissued block.
  assign accept  = !((wr_blk_q[BLK_W-1:0] == rd_ptr_q[PTR_W-2:IDX_W]) &&
                     (wr_blk_q[BLK_W] != rd_ptr_q[PTR_W-1]));

  assign wr_en     = bus.push_i && accept && !bus.flush_i && !rst_i;
  assign commit_en = bus.commit_i && accept;
  assign issue     = read_ok && (!valid_q || bus.pop_i);
  assign pop_en    = valid_q && bus.pop_i;

  always_comb begin
    wr_blk_d = wr_blk_q + (BLK_W+1)'(commit_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(issue);
    // A held word stays valid until popped; a new read refills the output register.
    valid_d  = issue || (valid_q && !bus.pop_i);
    level_d  = level_q + (commit_en ? BLK_WORDS : 32'd0) - 32'(pop_en);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      wr_blk_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      level_q  <= '0;
    end else begin
      wr_blk_q <= wr_blk_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
    end
  end

  // rdata_q only moves on a read issue, so it doubles as the skid register while stalled.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[{wr_blk_q[BLK_W-1:0], bus.wr_idx_i}] <= bus.data_in_i;
    end
    if (issue) begin
      rdata_q <= mem_q[rd_ptr_q[PTR_W-2:0]];
    end
  end

  assign bus.accept_o   = accept;
  assign bus.valid_o    = valid_q;
  assign bus.data_out_o = valid_q ? rdata_q : '0;
  assign bus.level_o    = level_q;
  assign bus.blocks_o   = wr_blk_q - rd_ptr_q[PTR_W-1:IDX_W];

endmodule
`default_nettype wire

// File: tb/tb_jpeg_output_block_buffer.sv
`default_nettype none
// ============================================================================
// tb_jpeg_output_block_buffer : scoreboard bench for the output block reorder buffer
// Rev 1.0
// ============================================================================
module tb_jpeg_output_block_buffer;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 6;
  localparam int BLK_W  = 3;
  localparam int PTR_W  = BLK_W + IDX_W + 1;
  localparam int BW     = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;

  jpeg_output_block_buffer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BLK_W(BLK_W)) bus ();

  jpeg_output_block_buffer #(.DATA_W(DATA_W), .IDX_W(IDX_W), .BLK_W(BLK_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_err    = 0;
  int n_popped = 0;

  // Reference model state and scoreboard of words in expected read order.
  logic [DATA_W-1:0] mmem [1 << (BLK_W + IDX_W)];
  logic [DATA_W-1:0] sbq [$];
  logic [BLK_W:0]    mwr;
  logic [PTR_W-1:0]  mrd;
  logic              mval;
  logic [31:0]       mlevel;

  task automatic model_clear();
    mwr = '0; mrd = '0; mval = 1'b0; mlevel = '0;
    sbq.delete();
  endtask

  task automatic scoreboard_monitor();
    logic              macc, missue;
    logic [DATA_W-1:0] exp_d;
    logic [BLK_W:0]    exp_blocks;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_clear();
      end else begin
        macc       = !((mwr[BLK_W-1:0] == mrd[PTR_W-2:IDX_W]) && (mwr[BLK_W] != mrd[PTR_W-1]));
        exp_d      = (mval && sbq.size() != 0) ? sbq[0] : '0;
        exp_blocks = mwr - mrd[PTR_W-1:IDX_W];
        n_vec++;
        if (bus.valid_o !== mval || bus.data_out_o !== exp_d) begin
          n_err++;
          $display("FAIL mon_out @%0t: valid_o=%0b data_out_o=%h, expected valid=%0b data=%h",
                   $time, bus.valid_o, bus.data_out_o, mval, exp_d);
        end
        n_vec++;
        if (bus.accept_o !== macc || bus.level_o !== mlevel || bus.blocks_o !== exp_blocks) begin
          n_err++;
          $display("FAIL mon_state @%0t: accept=%0b level=%0d blocks=%0d, expected %0b %0d %0d",
                   $time, bus.accept_o, bus.level_o, bus.blocks_o, macc, mlevel, exp_blocks);
        end
        if (bus.flush_i) begin
          model_clear();
        end else begin
          missue = (mrd != {mwr, {IDX_W{1'b0}}}) && (!mval || bus.pop_i);
          if (mval && bus.pop_i) begin
            void'(sbq.pop_front());
            mlevel = mlevel - 1;
            n_popped++;
          end
          if (bus.push_i && macc) mmem[{mwr[BLK_W-1:0], bus.wr_idx_i}] = bus.data_in_i;
          if (bus.commit_i && macc) begin
            for (int i = 0; i < BW; i++) sbq.push_back(mmem[{mwr[BLK_W-1:0], IDX_W'(i)}]);
            mwr    = mwr + 1'b1;
            mlevel = mlevel + BW;
          end
          if (missue) mrd = mrd + 1'b1;
          mval = missue || (mval && !bus.pop_i);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes one full block in a permuted index order, then commits it.
  task automatic write_block(input logic [31:0] base, input int stride, input bit desc,
                             input bit commit_with_last, input bit pop_on_last);
    int idx;
    for (int i = 0; i < BW; i++) begin
      idx = (i * stride) % BW;
      if (desc) idx = BW - 1 - idx;
      bus.push_i    = 1'b1;
      bus.wr_idx_i  = IDX_W'(idx);
      bus.data_in_i = base + 32'(idx);
      bus.commit_i  = commit_with_last && (i == BW - 1);
      if (pop_on_last && i == BW - 1) bus.pop_i = 1'b1;
      tick();
    end
    bus.push_i   = 1'b0;
    bus.commit_i = 1'b0;
    if (pop_on_last) bus.pop_i = 1'b0;
    if (!commit_with_last) begin
      bus.commit_i = 1'b1;
      tick();
      bus.commit_i = 1'b0;
    end
  endtask

  task automatic wait_empty(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      if (bus.level_o == 0 && !bus.valid_o) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_vec++; if (bus.accept_o !== 1'b1) begin n_err++; $display("FAIL %s_accept: got %0b want 1", tag, bus.accept_o); end
    n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL %s_valid: got %0b want 0", tag, bus.valid_o); end
    n_vec++; if (bus.data_out_o !== '0) begin n_err++; $display("FAIL %s_data: got %h want 0", tag, bus.data_out_o); end
    n_vec++; if (bus.level_o !== 32'd0) begin n_err++; $display("FAIL %s_level: got %0d want 0", tag, bus.level_o); end
    n_vec++; if (bus.blocks_o !== '0) begin n_err++; $display("FAIL %s_blocks: got %0d want 0", tag, bus.blocks_o); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_single_block();
    bit ok;
    bus.pop_i = 1'b1;
    write_block(32'h100, 1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %0b want 0", bus.valid_o); end
    n_vec++; if (bus.level_o !== 32'd64) begin n_err++; $display("FAIL single_level_commit: got %0d want 64", bus.level_o); end
    tick();
    for (int k = 0; k < BW; k++) begin
      n_vec++;
      if (bus.valid_o !== 1'b1 || bus.data_out_o !== 32'h100 + 32'(k)) begin
        n_err++;
        $display("FAIL single_stream[%0d]: got valid=%0b data=%h want valid=1 data=%h",
                 k, bus.valid_o, bus.data_out_o, 32'h100 + 32'(k));
      end
      tick();
    end
    n_vec++; if (bus.level_o !== 32'd0 || bus.valid_o !== 1'b0) begin n_err++; $display("FAIL single_end: got level=%0d valid=%0b want 0 0", bus.level_o, bus.valid_o); end
    bus.pop_i = 1'b0;
    wait_empty(4, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_empty: got not empty want empty"); end
  endtask

  task automatic test_fill();
    bit ok;
    int start;
    start = n_popped;
    bus.pop_i = 1'b0;
    for (int b = 0; b < 8; b++) write_block(32'h2000 + 32'(b) * 32'h100, 5, 1'b0, 1'b0, 1'b0);
    n_vec++; if (bus.accept_o !== 1'b0) begin n_err++; $display("FAIL fill_accept: got %0b want 0", bus.accept_o); end
    n_vec++; if (bus.level_o !== 32'd512) begin n_err++; $display("FAIL fill_level: got %0d want 512", bus.level_o); end
    n_vec++; if (bus.blocks_o !== 4'd8) begin n_err++; $display("FAIL fill_blocks: got %0d want 8", bus.blocks_o); end
    bus.push_i = 1'b1; bus.wr_idx_i = '0; bus.data_in_i = 32'hDEAD; bus.commit_i = 1'b1;
    tick();
    bus.push_i = 1'b0; bus.commit_i = 1'b0;
    n_vec++; if (bus.level_o !== 32'd512 || bus.blocks_o !== 4'd8) begin n_err++; $display("FAIL fill_ignored: got level=%0d blocks=%0d want 512 8", bus.level_o, bus.blocks_o); end
    bus.pop_i = 1'b1;
    for (int k = 1; k < BW; k++) begin
      tick();
      n_vec++;
      if (bus.accept_o !== (k == BW - 1)) begin
        n_err++;
        $display("FAIL fill_free[%0d]: got accept=%0b want %0b", k, bus.accept_o, (k == BW - 1));
      end
    end
    wait_empty(600, ok);
    bus.pop_i = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL fill_drain_timeout: got not empty want empty"); end
    n_vec++; if (n_popped - start !== 512) begin n_err++; $display("FAIL fill_popped: got %0d want 512", n_popped - start); end
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int start;
    int c;
    start = n_popped;
    bus.pop_i = 1'b0;
    write_block(32'h3000, 37, 1'b0, 1'b0, 1'b0);
    c = 0;
    while (c < 400 && !(bus.level_o == 0 && !bus.valid_o)) begin
      bus.pop_i = pat[c % 4];
      tick();
      c++;
    end
    bus.pop_i = 1'b0;
    n_vec++; if (c >= 400) begin n_err++; $display("FAIL bp_timeout: got %0d cycles want <400", c); end
    n_vec++; if (n_popped - start !== 64) begin n_err++; $display("FAIL bp_popped: got %0d want 64", n_popped - start); end
    n_vec++; if (bus.level_o !== 32'd0 || bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_end: got level=%0d valid=%0b want 0 0", bus.level_o, bus.valid_o); end
  endtask

  task automatic test_push_commit_same();
    bit ok;
    int start;
    start = n_popped;
    bus.pop_i = 1'b0;
    write_block(32'h4000, 1, 1'b0, 1'b1, 1'b0);
    n_vec++; if (bus.level_o !== 32'd64) begin n_err++; $display("FAIL pcs_level_a: got %0d want 64", bus.level_o); end
    tick(); tick();
    write_block(32'h4800, 1, 1'b0, 1'b1, 1'b1);
    n_vec++; if (bus.level_o !== 32'd127) begin n_err++; $display("FAIL pcs_level_pop: got %0d want 127", bus.level_o); end
    bus.pop_i = 1'b1;
    wait_empty(300, ok);
    bus.pop_i = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL pcs_drain_timeout: got not empty want empty"); end
    n_vec++; if (n_popped - start !== 128) begin n_err++; $display("FAIL pcs_popped: got %0d want 128", n_popped - start); end
  endtask

  task automatic test_flush();
    bit ok;
    bus.pop_i = 1'b0;
    write_block(32'h5000, 3, 1'b0, 1'b0, 1'b0);
    write_block(32'h5100, 9, 1'b1, 1'b0, 1'b0);
    bus.pop_i = 1'b1;
    repeat (5) tick();
    n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %0b want 1", bus.valid_o); end
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.pop_i   = 1'b0;
    check_reset_state("flush");
    tick();
    n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL flush_inflight: got valid=%0b want 0", bus.valid_o); end
    bus.pop_i = 1'b1;
    write_block(32'h5800, 3, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++; if (bus.valid_o !== 1'b1 || bus.data_out_o !== 32'h5800) begin n_err++; $display("FAIL flush_refill: got valid=%0b data=%h want 1 00005800", bus.valid_o, bus.data_out_o); end
    wait_empty(200, ok);
    bus.pop_i = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL flush_drain_timeout: got not empty want empty"); end
  endtask

  task automatic test_reset_midwrite();
    bit ok;
    int start;
    bus.pop_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.push_i = 1'b1; bus.wr_idx_i = IDX_W'(i); bus.data_in_i = 32'h6000 + 32'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.push_i = 1'b0;
    check_reset_state("rst_mid");
    start = n_popped;
    bus.pop_i = 1'b1;
    write_block(32'h7000, 7, 1'b0, 1'b0, 1'b0);
    wait_empty(200, ok);
    bus.pop_i = 1'b0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL rst_mid_drain_timeout: got not empty want empty"); end
    n_vec++; if (n_popped - start !== 64) begin n_err++; $display("FAIL rst_mid_popped: got %0d want 64", n_popped - start); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.push_i    = 1'b0;
    bus.commit_i  = 1'b0;
    bus.flush_i   = 1'b0;
    bus.pop_i     = 1'b0;
    bus.wr_idx_i  = '0;
    bus.data_in_i = '0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_single_block();
    test_fill();
    test_backpressure();
    test_push_commit_same();
    test_flush();
    test_reset_midwrite();
    n_vec++; if (sbq.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d words want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/jpeg_output_block_buffer.md
Name: jpeg_output_block_buffer

Overview:
- Parametrised block-granular output reorder buffer for the JPEG decoder output path.
- The IDCT/colour stage writes each block's words in any order using a per-block index.
- A block becomes readable only after it is committed.
- The reader drains committed words in address order through a 1-cycle-latency dual-port RAM with a valid/pop skid stage. Write-side back-pressure (accept_o) replaces silent overwrite.

Parameters:
- DATA_W, 32, data word width.
- IDX_W, 6, log2 words per block (64 words per block).
- BLK_W, 3, log2 block slots (8 slots). Must be ≥1.
- Derived: DEPTH = 2^(BLK_W+IDX_W) words; PTR_W = BLK_W+IDX_W+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wr_idx_i  in  IDX_W  word index within the current write block
- data_in_i  in  DATA_W  write data
- push_i  in  1  write data_in_i to slot wr_blk, index wr_idx_i
- commit_i  in  1  mark current write block complete; advance wr_blk
- accept_o  out  1  a free write slot exists; push/commit are honoured only when high
- flush_i  in  1  discard all contents
- pop_i  in  1  consumer takes data_out_o when valid_o=1
- data_out_o  out  DATA_W  head word; forced to 0 when valid_o=0
- valid_o  out  1  data_out_o is valid
- level_o  out  32  committed words not yet popped
- blocks_o  out  BLK_W+1  committed blocks not fully issued to RAM read

Behaviour:
- Reset: all pointers, counts and flags are 0. accept_o=1, valid_o=0, data_out_o=0, level_o=0, blocks_o=0.
- Flush: same effect as reset. It has priority over push, commit and pop in the same cycle. A RAM read in flight is discarded, and valid_o=0 on the next cycle.
- Write block pointer wr_blk_q is BLK_W+1 bits (wrap bit included).
- RAM write address = {wr_blk_q[BLK_W-1:0], wr_idx_i}.
- push with accept_o=1 writes in the same cycle. Indices may arrive in any order; a repeated index overwrites; unwritten indices read back as stale data.
- commit with accept_o=1: wr_blk_q += 1 and level += 2^IDX_W.
  - Push and commit in the same cycle: the push lands in the block being committed.
- With accept_o=0, push and commit are ignored: no write, no pointer change, no level change.
- Read pointer rd_ptr_q is PTR_W bits. Committed limit = {wr_blk_q, IDX_W'b0}. read_ok = (rd_ptr_q != limit).
- accept_o = !(wr_blk_q[BLK_W-1:0] == rd_ptr_q[PTR_W-2:IDX_W] && wr_blk_q[BLK_W] != rd_ptr_q[PTR_W-1]).
  - A slot frees on the cycle its last word read is issued.
- Read issue: when read_ok && (!valid_o || pop_i), the RAM is read at rd_ptr_q[PTR_W-2:0] and rd_ptr_q += 1.
  - Data appears 1 cycle later, with valid_o=1 via rd_q.
- Skid: if valid_o && !pop_i, the current data_out_o is captured and held (valid_o stays 1). data_out_o must not change while valid_o=1 and pop_i=0. Words are never duplicated or dropped.
- Back-to-back throughput: 1 word/cycle with pop_i held high. First word is valid 2 cycles after commit (commit cycle, then issue, then valid).
- level_o next = level + (2^IDX_W if commit accepted) − (1 if pop_i && valid_o). Both may occur in the same cycle.
- Pointer wrap: wrap bits distinguish full (all BLOCKS committed, accept_o=0) from empty (read_ok=0).
- Read/write ordering: a write to a freed slot in the same cycle as another slot's read has no interaction; same-address read/write cannot occur by construction.
- blocks_o = wr_blk_q − rd_ptr_q[PTR_W-1:IDX_W] (modulo 2^(BLK_W+1)).

Test Plan:
1. Single block, scrambled order: push indices 63..0 with data = 0x100 + idx, then commit, pop held high → 64 words 0x100..0x13F in index order; valid_o first high 2 cycles after commit; level_o 64→0.
2. Fill 8 blocks without popping → accept_o=0 after the 8th commit; 9th push/commit ignored; level_o=512; blocks_o=8. One pop at head → accept_o unchanged until the 64th read issue of block 0.
3. Back-pressure: pop_i toggled 1,0,0,1 during a drain → each word appears exactly once and data_out_o is stable while pop_i=0. Total 64 pops → level_o=0, valid_o=0.
4. Simultaneous push+commit of index 63, and commit in the same cycle as a pop → last word included in the block; level_o = prior + 64 − 1.
5. Flush mid-drain with 2 blocks committed and valid_o=1 → next cycle valid_o=0, level_o=0, accept_o=1, data_out_o=0. A new block written afterwards reads back correctly from slot 0.
6. Synchronous reset asserted mid-write with 10 words pushed and no commit → all outputs return to reset values; a subsequent commit of a fresh block drains only the new data.
